fft_sdf_stage_ctrl: RTL and testbench
=====================================

Name: fft_sdf_stage_ctrl

Overview:
- Frame sequencer for the 32-point radix-2 single-path-delay-feedback (SDF) FFT pipeline.
- Accepts input samples over a valid/ready handshake, counts shifts through the 5-stage pipeline and runs a 31-cycle drain after the last input.
- Drives per-stage butterfly/bypass selects and per-stage twiddle-ROM addresses; unused address slots resolve to W0 (1+j0) in the ROMs.
- Flags the 32 valid output samples and the frame end.

Parameters:
- LOG2N, 5, log2 of FFT size; N = 2^LOG2N stages = LOG2N. Only 5 is verified.
- ADDR_W, 6, twiddle address width (LOG2N+1; max address 47).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  controller accepts a sample this cycle.
- shift_en  out  1  advance all SDF delay lines and stage registers this cycle.
- stage_act  out  LOG2N  bit s high: stage s processes a frame sample this cycle.
- bf_sel  out  LOG2N  bit s: 1 = butterfly half, 0 = fill/bypass half.
- tw_addr  out  LOG2N*ADDR_W  stage s address in bits [s*ADDR_W +: ADDR_W].
- out_valid  out  1  pipeline output sample valid this cycle.
- out_last  out  1  last (32nd) output sample of the frame.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse after the out_last cycle.

Behaviour:
- State register: IDLE, RUN, FLUSH. Shift counter g: 6 bits. frame_done is registered.
- Reset (asynchronous, while rst is high):
  - state = IDLE, g = 0, frame_done = 0.
  - in_ready, shift_en, stage_act, bf_sel, tw_addr, out_valid, out_last and busy are all 0.
- in_ready = (state is IDLE or RUN) and rst low.
- shift_en = (in_valid and in_ready) or (state == FLUSH).
- Transitions and g updates:
  - IDLE: shift_en → RUN, g = 1. No shift → hold.
  - RUN: shift_en → g+1. A shift while g == 31 → FLUSH, g = 32. in_valid low → stall; g and state hold.
  - FLUSH: every cycle g+1. On g == 62 → IDLE, g = 0.
- Stage decode, all combinational from current g and shift_en:
  - Stage offset off_s = N − (N >> s) = {0, 16, 24, 28, 30}.
  - Delay D_s = N >> (s+1) = {16, 8, 4, 2, 1}.
  - Local index l_s = g − off_s, signed.
- stage_act[s] = shift_en and 0 ≤ l_s ≤ 31.
- bf_sel[s] = stage_act[s] and bit (LOG2N−1−s) of l_s.
- tw_addr_s = l_s + D_s when stage_act[s], otherwise 0.
  - Example, stage 2: l = 4..7 → 8..11, 12..15 → 16..19, 20..23 → 24..27, 28..31 → 32..35.
  - These are exactly that ROM's populated addresses; all other slots return W0.
- Output flags:
  - out_valid = shift_en and 31 ≤ g ≤ 62.
  - out_last = shift_en and g == 62.
  - frame_done = 1 in the cycle after out_last, otherwise 0.
- No frame overlap: the next frame's first sample is accepted only once state is IDLE, i.e. the cycle after out_last. That is the same cycle frame_done pulses.
- Boundary and illegal conditions:
  - in_valid during FLUSH is ignored (in_ready = 0) and must not disturb g.
  - A stall in RUN zeroes stage_act, bf_sel and tw_addr for that cycle.
  - rst asserted mid-frame aborts immediately to the reset values; the partial frame is discarded and the datapath is flushed by the next frame.
  - g never exceeds 62.

Test Plan:
- Reset then 32 back-to-back in_valid:
  - in_ready = 1 for cycles 0–31 and 0 for cycles 32–62; shift_en is high for 63 consecutive cycles.
  - out_valid is high for exactly 32 cycles (g = 31..62); out_last at g = 62; frame_done the next cycle; busy falls together with frame_done.
- Stage-2 address trace within the same frame:
  - At g = 28..35 (l = 4..11), tw_addr_2 = 8, 9, 10, 11, 12, 13, 14, 15 and bf_sel[2] = 1,1,1,1,0,0,0,0.
  - At g = 60 (l = 36), stage_act[2] = 0 and tw_addr_2 = 0.
- Stage 0 and 4 selects:
  - bf_sel[0] is 0 for g = 0..15 and 1 for g = 16..31.
  - bf_sel[4] toggles every shift for g = 30..61, starting at 0.
- Stalls in RUN: deassert in_valid for 3 cycles after sample 10.
  - g holds at 10, stage_act = 0 and tw_addr = 0 during the stall.
  - Resuming the frame gives the identical output sequence, with 3 cycles of extra length.
- in_valid held high through FLUSH and into the next frame:
  - No acceptance during FLUSH.
  - The next frame's sample 0 is accepted in the frame_done cycle, with g restarting at 1.
- Assert rst at g = 40:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a new frame starts cleanly with in_ready = 1.

Source files
------------

// File: rtl/fft_sdf_stage_ctrl.sv
// Frame sequencer for the 32-point radix-2 SDF FFT pipeline: input handshake, shift counting,
// per-stage butterfly/bypass selects, twiddle-ROM addresses and output framing.
module fft_sdf_stage_ctrl #(
    parameter int unsigned LOG2N  = 5,
    parameter int unsigned ADDR_W = LOG2N + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    shift_en,
    output logic [LOG2N-1:0]        stage_act,
    output logic [LOG2N-1:0]        bf_sel,
    output logic [LOG2N*ADDR_W-1:0] tw_addr,
    output logic                    out_valid,
    output logic                    out_last,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int unsigned N = 1 << LOG2N;
    localparam logic [ADDR_W-1:0] G_LAST_IN = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] G_END     = ADDR_W'(2 * N - 2);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] g, g_nx;
    logic [ADDR_W:0]   l_s [LOG2N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            g          <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            g          <= g_nx;
            frame_done <= out_last;
        end
    end

    always_comb begin
        state_nx = state;
        g_nx     = g;
        in_ready = ((state == IDLE) || (state == RUN)) && !rst;
        shift_en = (in_valid && in_ready) || (state == FLUSH);
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (shift_en) begin
                    state_nx = RUN;
                    g_nx     = ADDR_W'(1);
                end
            end
            RUN: begin
                if (shift_en) begin
                    if (g == G_LAST_IN) state_nx = FLUSH;
                    g_nx = g + 1'b1;
                end
            end
            FLUSH: begin
                if (g == G_END) begin
                    state_nx = IDLE;
                    g_nx     = '0;
                end else begin
                    g_nx = g + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                g_nx     = '0;
            end
        endcase
    end

    // l_s = g - off_s kept one bit wider than g; its MSB is the sign (sample not yet reached stage s)
    always_comb begin
        stage_act = '0;
        bf_sel    = '0;
        tw_addr   = '0;
        for (int unsigned s = 0; s < LOG2N; s++) begin
            l_s[s] = {1'b0, g} - (ADDR_W + 1)'(N - (N >> s));
            if (shift_en && !l_s[s][ADDR_W] && (l_s[s][ADDR_W-1:0] < ADDR_W'(N))) begin
                stage_act[s]               = 1'b1;
                bf_sel[s]                  = l_s[s][LOG2N-1-s];
                tw_addr[s*ADDR_W +: ADDR_W] = l_s[s][ADDR_W-1:0] + ADDR_W'(N >> (s + 1));
            end
        end
    end

    assign out_valid = shift_en && (g >= G_LAST_IN) && (g <= G_END);
    assign out_last  = shift_en && (g == G_END);

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Bench for fft_sdf_stage_ctrl: frame-progress model checked every cycle plus directed literal checks.
module tb_fft_sdf_stage_ctrl;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        shift_en;
    logic [4:0]  stage_act;
    logic [4:0]  bf_sel;
    logic [29:0] tw_addr;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        frame_done;

    fft_sdf_stage_ctrl #(.LOG2N(5), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .stage_act  (stage_act),
        .bf_sel     (bf_sel),
        .tw_addr    (tw_addr),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is 63 shifts; the first 32 consume input samples, the rest drain.
    int          m_shifts = 0;
    logic        m_prev_last = 1'b0;
    logic        e_rdy, e_sh, e_ov, e_ol;
    logic [4:0]  e_act, e_bf;
    logic [29:0] e_tw;
    int          m_l;

    always @(negedge clk) begin
        if (rst) begin
            m_shifts    = 0;
            m_prev_last = 1'b0;
        end
        e_rdy = !rst && (m_shifts < 32);
        e_sh  = (e_rdy && in_valid) || (!rst && m_shifts >= 32);
        e_act = '0;
        e_bf  = '0;
        e_tw  = '0;
        for (int s = 0; s < 5; s++) begin
            m_l = m_shifts - (32 - (32 >> s));
            if (e_sh && m_l >= 0 && m_l <= 31) begin
                e_act[s]       = 1'b1;
                e_bf[s]        = ((m_l >> (4 - s)) & 1) != 0;
                e_tw[s*6 +: 6] = 6'(m_l + (32 >> (s + 1)));
            end
        end
        e_ov = e_sh && (m_shifts >= 31);
        e_ol = e_sh && (m_shifts == 62);
        chk("in_ready",   in_ready,   e_rdy);
        chk("shift_en",   shift_en,   e_sh);
        chk("stage_act",  stage_act,  e_act);
        chk("bf_sel",     bf_sel,     e_bf);
        chk("tw_addr",    tw_addr,    e_tw);
        chk("out_valid",  out_valid,  e_ov);
        chk("out_last",   out_last,   e_ol);
        chk("busy",       busy,       m_shifts != 0);
        chk("frame_done", frame_done, m_prev_last);
        m_prev_last = e_ol;
        if (e_sh) m_shifts = (m_shifts == 62) ? 0 : m_shifts + 1;
    end

    logic [41:0] q1[$];
    logic [41:0] q2[$];
    int          n_ov;
    int          n_sh;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_tw", tw_addr, 30'd0);
        next_cycle();
        rst = 1'b0;

        // Frame 1: 32 back-to-back samples then drain
        n_ov = 0;
        n_sh = 0;
        for (int c = 0; c < 63; c++) begin
            in_valid = (c < 32);
            @(negedge clk);
            chk("f1_in_ready", in_ready, c < 32);
            chk("f1_shift_en", shift_en, 1'b1);
            chk("f1_out_valid", out_valid, c >= 31);
            chk("f1_out_last", out_last, c == 62);
            if (c >= 28 && c <= 35) begin
                chk("f1_tw2", tw_addr[12 +: 6], 6'(8 + c - 28));
                chk("f1_bf2", bf_sel[2], c < 32);
            end
            if (c == 60) begin
                chk("f1_act2_off", stage_act[2], 1'b0);
                chk("f1_tw2_off", tw_addr[12 +: 6], 6'd0);
            end
            if (c < 32) chk("f1_bf0", bf_sel[0], c >= 16);
            if (c >= 30 && c <= 61) chk("f1_bf4", bf_sel[4], ((c - 30) % 2) != 0);
            if (out_valid) n_ov++;
            if (shift_en) begin
                n_sh++;
                q1.push_back({stage_act, bf_sel, tw_addr, out_valid, out_last});
            end
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("f1_frame_done", frame_done, 1'b1);
        chk("f1_busy_fall", busy, 1'b0);
        chk("f1_in_ready_back", in_ready, 1'b1);
        chk("f1_n_out_valid", n_ov, 32);
        chk("f1_n_shift", n_sh, 63);
        next_cycle();

        // Frame 2: 3-cycle stall after sample 10
        n_sh = 0;
        for (int c = 0; c < 66; c++) begin
            in_valid = (c < 10) || (c >= 13 && c < 35);
            @(negedge clk);
            if (c >= 10 && c <= 12) begin
                chk("f2_stall_shift", shift_en, 1'b0);
                chk("f2_stall_act", stage_act, 5'd0);
                chk("f2_stall_tw", tw_addr, 30'd0);
                chk("f2_stall_busy", busy, 1'b1);
            end
            if (c == 13) chk("f2_resume_tw0", tw_addr[5:0], 6'd26);
            if (shift_en) begin
                n_sh++;
                q2.push_back({stage_act, bf_sel, tw_addr, out_valid, out_last});
            end
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("f2_frame_done", frame_done, 1'b1);
        chk("f2_n_shift", n_sh, 63);
        chk("f2_seq_len", q2.size(), q1.size());
        for (int i = 0; i < q1.size() && i < q2.size(); i++)
            chk("f2_seq", q2[i], q1[i]);
        next_cycle();

        // Frames 3/4: in_valid held high through drain and into the next frame
        for (int c = 0; c < 103; c++) begin
            in_valid = 1'b1;
            @(negedge clk);
            if (c >= 32 && c <= 62) chk("f3_no_accept", in_ready, 1'b0);
            if (c == 63) begin
                chk("f4_frame_done", frame_done, 1'b1);
                chk("f4_in_ready", in_ready, 1'b1);
                chk("f4_shift", shift_en, 1'b1);
                chk("f4_act", stage_act, 5'b00001);
                chk("f4_tw0_first", tw_addr[5:0], 6'd16);
            end
            if (c == 64) chk("f4_tw0_second", tw_addr[5:0], 6'd17);
            next_cycle();
        end
        // Frame 4 now sits at g = 40: abort asynchronously
        rst = 1'b1;
        #1;
        chk("abort_shift", shift_en, 1'b0);
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_act", stage_act, 5'd0);
        chk("abort_tw", tw_addr, 30'd0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        next_cycle();
        next_cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        next_cycle();

        // Frame 5: clean frame after abort
        for (int c = 0; c < 63; c++) begin
            in_valid = (c < 32);
            @(negedge clk);
            if (c == 0) chk("f5_tw0_first", tw_addr[5:0], 6'd16);
            if (c == 62) chk("f5_out_last", out_last, 1'b1);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("f5_frame_done", frame_done, 1'b1);
        next_cycle();
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
